// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imem_arbiter
// Brief    : Shares a single-port synchronous-read instruction memory between
//            the fetch stage and the data side, with fetch anti-starvation.
// Revision : 1.0 - initial release
// ============================================================================
module imem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_valid_i,
    output logic              f_ready_o,
    input  logic [ADDR_W-1:0] f_addr_i,
    input  logic              f_flush_i,
    output logic              f_rvalid_o,
    output logic [DATA_W-1:0] f_rdata_o,
    input  logic              d_valid_i,
    output logic              d_ready_o,
    input  logic [ADDR_W-1:0] d_addr_i,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

    logic       fv;
    logic       fetch_pri;
    logic       gnt_f;
    logic       gnt_d;
    logic       resp_f_q, resp_f_d;
    logic       resp_d_q, resp_d_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;

    always_comb begin
        fv        = f_valid_i & ~f_flush_i;
        fetch_pri = (starve_cnt_q == c_starve_max);
        gnt_d     = d_valid_i & ~(fv & fetch_pri);
        gnt_f     = fv & ~gnt_d;
    end

    always_comb begin
        mem_addr_o = '0;
        if (gnt_d) begin
            mem_addr_o = d_addr_i;
        end else if (gnt_f) begin
            mem_addr_o = f_addr_i;
        end
    end

    // A fetch that lost arbitration ages the counter; anything else (fetch
    // won, or no live fetch request) restarts the starvation window.
    always_comb begin
        resp_f_d     = gnt_f;
        resp_d_d     = gnt_d;
        starve_cnt_d = 4'd0;
        if (fv && gnt_d) begin
            starve_cnt_d = fetch_pri ? starve_cnt_q : starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_f_q     <= 1'b0;
            resp_d_q     <= 1'b0;
            starve_cnt_q <= 4'd0;
        end else begin
            resp_f_q     <= resp_f_d;
            resp_d_q     <= resp_d_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign f_ready_o  = gnt_f;
    assign d_ready_o  = gnt_d;
    assign mem_en_o   = gnt_f | gnt_d;
    // Flush kills the fetch word returning this cycle; it was fetched down the
    // wrong path.
    assign f_rvalid_o = resp_f_q & ~f_flush_i;
    assign d_rvalid_o = resp_d_q;
    assign f_rdata_o  = mem_rdata_i;
    assign d_rdata_o  = mem_rdata_i;

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_imem_arbiter
// Brief    : Directed self-checking bench for imem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_valid_i, f_flush_i, d_valid_i;
    logic [31:0] f_addr_i, d_addr_i;
    logic        f_ready_o, f_rvalid_o, d_ready_o, d_rvalid_o, mem_en_o;
    logic [31:0] f_rdata_o, d_rdata_o, mem_addr_o;
    logic [31:0] mem_rdata_i = 32'h0;

    int n_checks = 0;
    int n_pass   = 0;

    imem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .f_valid_i   (f_valid_i),
        .f_ready_o   (f_ready_o),
        .f_addr_i    (f_addr_i),
        .f_flush_i   (f_flush_i),
        .f_rvalid_o  (f_rvalid_o),
        .f_rdata_o   (f_rdata_o),
        .d_valid_i   (d_valid_i),
        .d_ready_o   (d_ready_o),
        .d_addr_i    (d_addr_i),
        .d_rvalid_o  (d_rvalid_o),
        .d_rdata_o   (d_rdata_o),
        .mem_en_o    (mem_en_o),
        .mem_addr_o  (mem_addr_o),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk = ~clk;

    // Memory contents: a few real instructions at the bottom, a pattern elsewhere
    function automatic logic [31:0] word(input logic [31:0] a);
        case (a)
            32'h0:   word = 32'h0000_0013;
            32'h4:   word = 32'h0010_0093;
            32'h8:   word = 32'h0020_0113;
            default: word = a ^ 32'h5A5A_0000;
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_en_o) mem_rdata_i <= word(mem_addr_o);
    end

    // Tasks start and end 1ns after a rising edge; checks happen 4ns in.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        f_valid_i = 1'b0; d_valid_i = 1'b0; f_flush_i = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1; f_valid_i = 1'b0; d_valid_i = 1'b0; f_flush_i = 1'b0;
        f_addr_i = 32'h0; d_addr_i = 32'h0;
        #3;
        n_checks++;
        if ({f_rvalid_o, d_rvalid_o, mem_en_o} !== 3'b000)
            $display("FAIL reset_outputs: got %b expected 000", {f_rvalid_o, d_rvalid_o, mem_en_o});
        else n_pass++;
        next_cycle();
        rst = 1'b0;
        next_cycle();
        f_valid_i = 1'b1; f_addr_i = 32'h40;
        #3;
        n_checks++;
        if (f_ready_o !== 1'b1) $display("FAIL reset_pre_grant: got %b expected 1", f_ready_o);
        else n_pass++;
        next_cycle();
        f_valid_i = 1'b0; rst = 1'b1;
        #3;
        n_checks++;
        if ({f_rvalid_o, mem_en_o} !== 2'b00)
            $display("FAIL reset_midstream: rvalid,en got %b expected 00", {f_rvalid_o, mem_en_o});
        else n_pass++;
        next_cycle();
        rst = 1'b0;
        #3;
        n_checks++;
        if ({f_rvalid_o, mem_en_o} !== 2'b00)
            $display("FAIL reset_release: rvalid,en got %b expected 00", {f_rvalid_o, mem_en_o});
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_fetch_only();
        logic [31:0] addrs [3] = '{32'h0, 32'h4, 32'h8};
        logic [31:0] words [3] = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113};
        for (int i = 0; i < 4; i++) begin
            f_valid_i = (i < 3);
            f_addr_i  = (i < 3) ? addrs[i] : 32'h0;
            #3;
            if (i < 3) begin
                n_checks++;
                if ({f_ready_o, mem_en_o, mem_addr_o} !== {2'b11, addrs[i]})
                    $display("FAIL fetch_grant[%0d]: rdy,en,addr got %b,%b,%h expected 1,1,%h",
                             i, f_ready_o, mem_en_o, mem_addr_o, addrs[i]);
                else n_pass++;
            end
            n_checks++;
            if (i == 0) begin
                if (f_rvalid_o !== 1'b0) $display("FAIL fetch_rvalid[0]: got %b expected 0", f_rvalid_o);
                else n_pass++;
            end else begin
                if ({f_rvalid_o, f_rdata_o} !== {1'b1, words[i-1]})
                    $display("FAIL fetch_resp[%0d]: got %b,%h expected 1,%h",
                             i, f_rvalid_o, f_rdata_o, words[i-1]);
                else n_pass++;
            end
            next_cycle();
        end
    endtask

    task automatic test_conflict();
        logic exp_f [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        f_valid_i = 1'b1; d_valid_i = 1'b1; f_addr_i = 32'h300; d_addr_i = 32'h800;
        for (int i = 0; i <= 10; i++) begin
            if (i == 10) begin f_valid_i = 1'b0; d_valid_i = 1'b0; end
            #3;
            if (i < 10) begin
                n_checks++;
                if ({f_ready_o, d_ready_o, mem_addr_o} !==
                    {exp_f[i], ~exp_f[i], (exp_f[i] ? 32'h300 : 32'h800)})
                    $display("FAIL conflict_grant[%0d]: f,d,addr got %b,%b,%h expected %b,%b,%h",
                             i, f_ready_o, d_ready_o, mem_addr_o, exp_f[i], ~exp_f[i],
                             (exp_f[i] ? 32'h300 : 32'h800));
                else n_pass++;
            end
            if (i > 0) begin
                n_checks++;
                if ({f_rvalid_o, d_rvalid_o, f_rdata_o} !==
                    {exp_f[i-1], ~exp_f[i-1], word(exp_f[i-1] ? 32'h300 : 32'h800)})
                    $display("FAIL conflict_resp[%0d]: frv,drv,data got %b,%b,%h expected %b,%b,%h",
                             i, f_rvalid_o, d_rvalid_o, f_rdata_o, exp_f[i-1], ~exp_f[i-1],
                             word(exp_f[i-1] ? 32'h300 : 32'h800));
                else n_pass++;
            end
            next_cycle();
        end
    endtask

    task automatic test_flush_resp();
        f_valid_i = 1'b1; f_addr_i = 32'h100;
        #3;
        n_checks++;
        if (f_ready_o !== 1'b1) $display("FAIL flush_n_grant: got %b expected 1", f_ready_o);
        else n_pass++;
        next_cycle();
        f_flush_i = 1'b1; f_addr_i = 32'h200;
        #3;
        n_checks++;
        if ({f_rvalid_o, f_ready_o, mem_en_o} !== 3'b000)
            $display("FAIL flush_n1: rvalid,ready,en got %b expected 000", {f_rvalid_o, f_ready_o, mem_en_o});
        else n_pass++;
        next_cycle();
        f_flush_i = 1'b0;
        #3;
        n_checks++;
        if ({f_ready_o, f_rvalid_o, mem_addr_o} !== {2'b10, 32'h200})
            $display("FAIL flush_n2: ready,rvalid,addr got %b,%b,%h expected 1,0,00000200",
                     f_ready_o, f_rvalid_o, mem_addr_o);
        else n_pass++;
        next_cycle();
        f_valid_i = 1'b0;
        #3;
        n_checks++;
        if ({f_rvalid_o, f_rdata_o} !== {1'b1, word(32'h200)})
            $display("FAIL flush_n3: got %b,%h expected 1,%h", f_rvalid_o, f_rdata_o, word(32'h200));
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_flush_data();
        d_valid_i = 1'b1; d_addr_i = 32'h900;
        #3;
        n_checks++;
        if (d_ready_o !== 1'b1) $display("FAIL flushd_grant: got %b expected 1", d_ready_o);
        else n_pass++;
        next_cycle();
        d_valid_i = 1'b0; f_flush_i = 1'b1; f_valid_i = 1'b1;
        #3;
        n_checks++;
        if ({d_rvalid_o, d_rdata_o, f_rvalid_o} !== {1'b1, word(32'h900), 1'b0})
            $display("FAIL flushd_resp: drv,data,frv got %b,%h,%b expected 1,%h,0",
                     d_rvalid_o, d_rdata_o, f_rvalid_o, word(32'h900));
        else n_pass++;
        next_cycle();
        f_valid_i = 1'b0; f_flush_i = 1'b0;
        next_cycle();
    endtask

    task automatic test_counter_reset();
        logic exp_f [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
        f_addr_i = 32'h340; d_addr_i = 32'hA00; d_valid_i = 1'b1;
        // 3 denials, one cycle with no fetch, then 4 more denials before fetch wins
        for (int i = 0; i < 9; i++) begin
            f_valid_i = (i != 3);
            #3;
            n_checks++;
            if ({f_ready_o, d_ready_o} !== {exp_f[i], ~exp_f[i]})
                $display("FAIL counter_grant[%0d]: f,d got %b,%b expected %b,%b",
                         i, f_ready_o, d_ready_o, exp_f[i], ~exp_f[i]);
            else n_pass++;
            next_cycle();
        end
        f_valid_i = 1'b0; d_valid_i = 1'b0;
        #3;
        n_checks++;
        if ({f_rvalid_o, d_rvalid_o, mem_en_o} !== 3'b100)
            $display("FAIL counter_tail: frv,drv,en got %b expected 100", {f_rvalid_o, d_rvalid_o, mem_en_o});
        else n_pass++;
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        idle();
        test_conflict();
        idle();
        test_flush_resp();
        idle();
        test_flush_data();
        idle();
        test_counter_reset();
        idle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
